// File: rtl/i2c_slave_reg_port.sv
// I2C responder exposing a local register file: START/STOP decode, 7-bit chip
// address match, big-endian register pointer, auto-incrementing word access.
module i2c_slave_reg_port #(
  parameter int NUM_ADDR_BYTES = 2,
  parameter int NUM_DATA_BYTES = 1,
  localparam int AW = (NUM_ADDR_BYTES == 0) ? 1 : 8*NUM_ADDR_BYTES,
  localparam int DW = 8*NUM_DATA_BYTES
) (
  input  logic          ifclk,
  input  logic          resetb,
  input  logic [6:0]    chip_addr,
  input  logic          sda_in,
  input  logic          scl_in,
  output logic          sda_out,
  output logic          sda_oeb,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_datao,
  output logic          reg_we,
  output logic          reg_re,
  input  logic [DW-1:0] reg_datai,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RADDR, RADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } st_t;

  st_t           st;
  logic [1:0]    scl_s, sda_s;
  logic          scl_d, sda_d;
  logic          scl_rise, scl_fall, start, stop;
  logic [6:0]    sr;
  logic [7:0]    byte_in;
  logic [2:0]    bit_cnt, abyte_cnt, dbyte_cnt;
  logic [1:0]    ph;
  logic          rw, rd_pend;
  logic [AW-1:0] addr_sh;
  logic [DW-1:0] wsh, tx;

  assign sda_out  = 1'b0;
  assign scl_rise = scl_s[1] & ~scl_d;
  assign scl_fall = ~scl_s[1] & scl_d;
  assign start    = scl_s[1] & scl_d & sda_d & ~sda_s[1];
  assign stop     = scl_s[1] & scl_d & ~sda_d & sda_s[1];
  assign byte_in  = {sr, sda_s[1]};

  // Pad synchronizers plus one delayed copy for edge detection (idle bus is high).
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      scl_s <= 2'b11; sda_s <= 2'b11; scl_d <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl_in};
      sda_s <= {sda_s[0], sda_in};
      scl_d <= scl_s[1];
      sda_d <= sda_s[1];
    end
  end

  // Protocol FSM: bits sampled on SCL rise, SDA only changed on SCL fall.
  // ph sequences the ACK slot: drive/release on falls, master ACK on a rise.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      st <= IDLE; sda_oeb <= 1'b1; reg_we <= 1'b0; reg_re <= 1'b0;
      reg_addr <= '0; reg_datao <= '0; busy <= 1'b0;
      sr <= '0; bit_cnt <= '0; abyte_cnt <= '0; dbyte_cnt <= '0; ph <= '0;
      rw <= 1'b0; rd_pend <= 1'b0; addr_sh <= '0; wsh <= '0; tx <= '0;
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      rd_pend <= reg_re;
      // pointer advances the cycle after a write strobe
      if (reg_we) reg_addr <= reg_addr + AW'(1);
      if (stop) begin
        st <= IDLE; busy <= 1'b0; sda_oeb <= 1'b1;
      end else if (start) begin
        st <= ADDR; bit_cnt <= '0; ph <= '0; sda_oeb <= 1'b1;
      end else begin
        case (st)
          ADDR: if (scl_rise) begin
            sr <= byte_in[6:0]; bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_in[7:1] == chip_addr) begin
                st <= ADDR_ACK; busy <= 1'b1; rw <= byte_in[0]; ph <= '0;
              end else begin
                st <= IGNORE; busy <= 1'b0;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (ph == 2'd0) begin
              sda_oeb <= 1'b0; ph <= 2'd1;
              if (rw) reg_re <= 1'b1;
            end else begin
              ph <= '0; bit_cnt <= '0; abyte_cnt <= '0; dbyte_cnt <= '0;
              if (rw) begin
                st <= RDATA; sda_oeb <= tx[DW-1]; tx <= tx << 1;
              end else begin
                sda_oeb <= 1'b1;
                st <= (NUM_ADDR_BYTES == 0) ? WDATA : RADDR;
              end
            end
          end
          RADDR: if (scl_rise) begin
            sr <= byte_in[6:0]; bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              addr_sh <= AW'({addr_sh, byte_in});
              abyte_cnt <= abyte_cnt + 3'd1;
              st <= RADDR_ACK; ph <= '0;
              if (abyte_cnt == 3'(NUM_ADDR_BYTES-1)) reg_addr <= AW'({addr_sh, byte_in});
            end
          end
          RADDR_ACK: if (scl_fall) begin
            if (ph == 2'd0) begin
              sda_oeb <= 1'b0; ph <= 2'd1;
            end else begin
              sda_oeb <= 1'b1; ph <= '0; bit_cnt <= '0;
              st <= (abyte_cnt == 3'(NUM_ADDR_BYTES)) ? WDATA : RADDR;
            end
          end
          WDATA: if (scl_rise) begin
            sr <= byte_in[6:0]; bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wsh <= DW'({wsh, byte_in});
              st <= WDATA_ACK; ph <= '0;
              if (dbyte_cnt == 3'(NUM_DATA_BYTES-1)) begin
                reg_datao <= DW'({wsh, byte_in}); reg_we <= 1'b1; dbyte_cnt <= '0;
              end else begin
                dbyte_cnt <= dbyte_cnt + 3'd1;
              end
            end
          end
          WDATA_ACK: if (scl_fall) begin
            if (ph == 2'd0) begin
              sda_oeb <= 1'b0; ph <= 2'd1;
            end else begin
              sda_oeb <= 1'b1; ph <= '0; bit_cnt <= '0; st <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin st <= RDATA_ACK; ph <= '0; end
            end
            if (scl_fall) begin sda_oeb <= tx[DW-1]; tx <= tx << 1; end
          end
          RDATA_ACK: begin
            if (scl_fall) begin
              if (ph == 2'd0) begin
                sda_oeb <= 1'b1; ph <= 2'd1;
              end else if (ph == 2'd2) begin
                st <= RDATA; bit_cnt <= '0; sda_oeb <= tx[DW-1]; tx <= tx << 1;
              end
            end
            if (scl_rise && ph == 2'd1) begin
              if (sda_s[1]) begin
                st <= IGNORE;
              end else begin
                ph <= 2'd2;
                if (dbyte_cnt == 3'(NUM_DATA_BYTES-1)) begin
                  dbyte_cnt <= '0; reg_addr <= reg_addr + AW'(1); reg_re <= 1'b1;
                end else begin
                  dbyte_cnt <= dbyte_cnt + 3'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
      // read word arrives the cycle after the strobe
      if (rd_pend) tx <= reg_datai;
    end
  end

endmodule

// File: tb/tb_i2c_slave_reg_port.sv
// Directed bench: bit-level I2C master model, scoreboard queues for strobes.
module tb_i2c_slave_reg_port;

  localparam int Q = 50;  // quarter SCL period; ifclk period is 10

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        ifclk = 1'b0;
  logic        resetb = 1'b0;
  logic [6:0]  chip_addr = 7'h50;
  logic        sda_m = 1'b1, scl_m = 1'b1;
  logic        sda_in, scl_in;
  logic        sda_out, sda_oeb;
  logic [15:0] reg_addr;
  logic [7:0]  reg_datao;
  logic        reg_we, reg_re;
  logic [7:0]  reg_datai = 8'h00;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_byte[$];
  logic [7:0]  mem [256];

  assign sda_in = sda_m & sda_oeb;
  assign scl_in = scl_m;

  always #5 ifclk = ~ifclk;

  i2c_slave_reg_port #(.NUM_ADDR_BYTES(2), .NUM_DATA_BYTES(1)) dut (
    .ifclk(ifclk), .resetb(resetb), .chip_addr(chip_addr),
    .sda_in(sda_in), .scl_in(scl_in), .sda_out(sda_out), .sda_oeb(sda_oeb),
    .reg_addr(reg_addr), .reg_datao(reg_datao), .reg_we(reg_we), .reg_re(reg_re),
    .reg_datai(reg_datai), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b1; #(2*Q);
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b; #(Q); scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); b = sda_in; #(Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) rd_bit(d[i]);
    wr_bit(nack);
  endtask

  // Strobe monitor: compares every strobe against the scoreboard, serves reads.
  always @(negedge ifclk) begin
    if (resetb) begin
      if (reg_we) begin
        check("we_expected", 32'(exp_wr.size() != 0), 32'd1);
        check("we_re_excl", 32'(reg_re), 32'd0);
        if (exp_wr.size() != 0) begin
          wr_t e;
          e = exp_wr.pop_front();
          check("we_addr", 32'(reg_addr), 32'(e.addr));
          check("we_data", 32'(reg_datao), 32'(e.data));
        end
      end
      if (reg_re) begin
        check("re_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) check("re_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
        reg_datai = mem[reg_addr[7:0]];
      end
    end
  end

  initial begin
    logic       ack, b;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'h3C;
    mem[8'h11] = 8'hC3;

    // reset values, lines wiggling under reset
    #(23);
    check("rst_sda_oeb", 32'(sda_oeb), 32'd1);
    check("rst_sda_out", 32'(sda_out), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_re", 32'(reg_re), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_datao", 32'(reg_datao), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      scl_m = ~scl_m; #(Q); sda_m = ~sda_m; #(Q);
      check("rst_toggle_oeb", 32'(sda_oeb), 32'd1);
    end
    sda_m = 1'b1; scl_m = 1'b1; #(2*Q);
    resetb = 1'b1; #(4*Q);

    // write 0x55,0x66 starting at 0x1234
    i2c_start();
    wr_byte(8'hA0, ack); check("w_ack_dev", 32'(ack), 32'd0);
    check("w_busy", 32'(busy), 32'd1);
    wr_byte(8'h12, ack); check("w_ack_a1", 32'(ack), 32'd0);
    wr_byte(8'h34, ack); check("w_ack_a0", 32'(ack), 32'd0);
    exp_wr.push_back('{16'h1234, 8'h55});
    wr_byte(8'h55, ack); check("w_ack_d0", 32'(ack), 32'd0);
    exp_wr.push_back('{16'h1235, 8'h66});
    wr_byte(8'h66, ack); check("w_ack_d1", 32'(ack), 32'd0);
    i2c_stop();
    check("w_busy_stop", 32'(busy), 32'd0);
    check("w_addr_after", 32'(reg_addr), 32'h1236);

    // set pointer 0x0010, repeated START, read two bytes
    i2c_start();
    wr_byte(8'hA0, ack); check("r_ack_dev", 32'(ack), 32'd0);
    wr_byte(8'h00, ack); check("r_ack_a1", 32'(ack), 32'd0);
    wr_byte(8'h10, ack); check("r_ack_a0", 32'(ack), 32'd0);
    exp_rd.push_back(16'h0010);
    exp_byte.push_back(8'h3C);
    i2c_start();
    wr_byte(8'hA1, ack); check("r_ack_rd", 32'(ack), 32'd0);
    exp_rd.push_back(16'h0011);
    exp_byte.push_back(8'hC3);
    rd_byte(1'b0, d); check("r_byte0", 32'(d), 32'(exp_byte.pop_front()));
    rd_byte(1'b1, d); check("r_byte1", 32'(d), 32'(exp_byte.pop_front()));
    rd_bit(b); check("r_ignore_rel", 32'(b), 32'd1);
    check("r_ignore_busy", 32'(busy), 32'd1);
    i2c_stop();
    check("r_busy_stop", 32'(busy), 32'd0);
    check("r_addr_after", 32'(reg_addr), 32'h0011);

    // wrong device address is NACKed and ignored
    i2c_start();
    wr_byte(8'hA2, ack); check("m_nack", 32'(ack), 32'd1);
    check("m_busy", 32'(busy), 32'd0);
    wr_byte(8'h00, ack); check("m_nack_data", 32'(ack), 32'd1);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA0, ack); check("m_ack_after", 32'(ack), 32'd0);
    i2c_stop();
    check("m_addr_kept", 32'(reg_addr), 32'h0011);

    // STOP in the middle of a data byte: no write
    i2c_start();
    wr_byte(8'hA0, ack); check("p_ack_dev", 32'(ack), 32'd0);
    wr_byte(8'h00, ack); check("p_ack_a1", 32'(ack), 32'd0);
    wr_byte(8'h20, ack); check("p_ack_a0", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) wr_bit(1'(i));
    i2c_stop();
    check("p_addr", 32'(reg_addr), 32'h0020);
    check("p_busy", 32'(busy), 32'd0);

    // pointer wrap at 0xFFFF
    i2c_start();
    wr_byte(8'hA0, ack); check("x_ack_dev", 32'(ack), 32'd0);
    wr_byte(8'hFF, ack); check("x_ack_a1", 32'(ack), 32'd0);
    wr_byte(8'hFF, ack); check("x_ack_a0", 32'(ack), 32'd0);
    exp_wr.push_back('{16'hFFFF, 8'hAA});
    wr_byte(8'hAA, ack); check("x_ack_d0", 32'(ack), 32'd0);
    exp_wr.push_back('{16'h0000, 8'hBB});
    wr_byte(8'hBB, ack); check("x_ack_d1", 32'(ack), 32'd0);
    i2c_stop();
    check("x_addr_wrap", 32'(reg_addr), 32'h0001);

    // reset during the ACK slot releases SDA at once
    i2c_start();
    for (int i = 7; i >= 0; i--) wr_bit(1'(8'hA0 >> i));
    check("a_ack_driven", 32'(sda_oeb), 32'd0);
    #(2); resetb = 1'b0; #(1);
    check("a_rst_release", 32'(sda_oeb), 32'd1);
    check("a_rst_busy", 32'(busy), 32'd0);
    check("a_rst_addr", 32'(reg_addr), 32'd0);
    #(2*Q); resetb = 1'b1; #(2*Q);
    i2c_stop();

    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
